fir_tap_sched: RTL

- Time-multiplexed FIR controller: one shared fpu_mul and one shared fpu_add serve all TAPS taps of a single-precision FIR filter.
- Owns the sample delay line (ring buffer) and the coefficient register file.
- Sequences multiply/accumulate per tap, accounting for the fixed pipeline latencies of the shared units.
- Sits between a sample source (valid/ready) and a result sink (valid/ready). Replaces the fully parallel multiplier/adder tree where area matters more than throughput.

---
 rtl/fir_tap_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fir_tap_sched.sv
// fir_tap_sched: time-multiplexed FIR MAC sequencer driving one shared fpu_mul and fpu_add; FIR_TAP_SCHED_STALL_CNT_EN adds a stall counter.
// Latency: accept to out_valid = 1 + TAPS*(MUL_LAT+1) + (TAPS-1)*(ADD_LAT+1) cycles (36 at defaults).
// Backpressure: in_ready only while IDLE; the result is held in OUT until out_ready; one sample in flight.
`timescale 1ns/1ps
module fir_tap_sched #(
    parameter int TAPS    = 4,
    parameter int ADDR_W  = 2,
    parameter int MUL_LAT = 4,
    parameter int ADD_LAT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [31:0]       coef_wdata,
    output logic              coef_err,
    output logic [31:0]       mul_opa,
    output logic [31:0]       mul_opb,
    input  logic [31:0]       mul_out,
    output logic [31:0]       add_opa,
    output logic [31:0]       add_opb,
    input  logic [31:0]       add_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              busy
`ifdef FIR_TAP_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [2:0] {IDLE, MUL, MWAIT, ADD, AWAIT, OUT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       coef  [TAPS];
    logic [31:0]       dline [TAPS];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tap;
    logic [ADDR_W-1:0] ridx;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       acc;
    logic [31:0]       prod;
    logic              accept;
    logic              coef_ok;
    logic              mul_cap;
    logic              add_cap;
    logic              last_tap;

    assign accept   = (state == IDLE) && in_valid && !reset;
    assign coef_ok  = (state == IDLE) && (int'(coef_addr) < TAPS);
    // The shared units have no valid flag: capture on a fixed count only.
    assign mul_cap  = (state == MWAIT) && (cnt == CNT_W'(MUL_LAT - 1));
    assign add_cap  = (state == AWAIT) && (cnt == CNT_W'(ADD_LAT - 1));
    assign last_tap = (tap == ADDR_W'(TAPS - 1));

    // Ring index of x[n-tap], modulo TAPS (TAPS need not be a power of two).
    always_comb begin
        ridx = '0;
        if (head >= tap) begin
            ridx = head - tap;
        end else begin
            ridx = ADDR_W'(TAPS + int'(head) - int'(tap));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        mul_opa   = '0;
        mul_opb   = '0;
        add_opa   = '0;
        add_opb   = '0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !reset;
                if (accept) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                mul_opa   = coef[tap];
                mul_opb   = dline[ridx];
                state_nxt = MWAIT;
            end
            MWAIT: begin
                mul_opa = coef[tap];
                mul_opb = dline[ridx];
                if (mul_cap) begin
                    if (tap != '0) begin
                        state_nxt = ADD;
                    end else if (TAPS == 1) begin
                        state_nxt = OUT;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            ADD: begin
                add_opa   = acc;
                add_opb   = prod;
                state_nxt = AWAIT;
            end
            AWAIT: begin
                add_opa = acc;
                add_opb = prod;
                if (add_cap) begin
                    state_nxt = last_tap ? OUT : MUL;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = acc;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            head     <= '0;
            tap      <= '0;
            cnt      <= '0;
            acc      <= '0;
            prod     <= '0;
            coef_err <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i]  <= '0;
                dline[i] <= '0;
            end
        end else begin
            coef_err <= coef_we && !coef_ok;
            // Lands in the same edge as an accept, so MUL sees the new value.
            if (coef_we && coef_ok) begin
                coef[coef_addr] <= coef_wdata;
            end
            if (accept) begin
                dline[wptr] <= in_data;
                head        <= wptr;
                wptr        <= last_wptr(wptr) ? '0 : wptr + ADDR_W'(1);
                tap         <= '0;
            end
            case (state)
                MUL, ADD: cnt <= '0;
                MWAIT: begin
                    if (mul_cap) begin
                        prod <= mul_out;
                        if (tap == '0) begin
                            acc <= mul_out;
                            tap <= tap + ADDR_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                AWAIT: begin
                    if (add_cap) begin
                        acc <= add_out;
                        if (!last_tap) begin
                            tap <= tap + ADDR_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic last_wptr(input logic [ADDR_W-1:0] p);
        return p == ADDR_W'(TAPS - 1);
    endfunction

`ifdef FIR_TAP_SCHED_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
